// File: rtl/mac_accumulator_if.sv
// Handshake bundle between the product source, mac_accumulator and the result consumer.
// master: the side that drives products and consumes results; slave: the accumulator.
interface mac_accumulator_if #(
  parameter int unsigned PROD_W = 64,
  parameter int unsigned LEN_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [PROD_W-1:0] prod;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] res;
  logic              res_sat;
  logic              res_valid;
  logic              res_ready;
  logic              busy;

  modport master (
    output start, len, prod, prod_valid, res_ready,
    input  prod_ready, res, res_sat, res_valid, busy
  );

  modport slave (
    input  start, len, prod, prod_valid, res_ready,
    output prod_ready, res, res_sat, res_valid, busy
  );
endinterface

// File: rtl/mac_accumulator.sv
// Sums a burst of signed products in a wide accumulator and emits one saturated result
// per burst over a valid/ready handshake.
module mac_accumulator #(
  parameter int unsigned PROD_W = 64,
  parameter int unsigned ACC_W  = 72,
  parameter int unsigned LEN_W  = 8
) (
  input logic              clk,
  input logic              rst,
  mac_accumulator_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StSat, StHold} state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]        count_q, count_d;
  logic [PROD_W-1:0]       res_q, res_d;
  logic                    res_sat_q, res_sat_d;

  logic                    accept;
  logic signed [ACC_W-1:0] prod_ext;
  logic [ACC_W-PROD_W:0]   top_bits;
  logic                    pos_ovf, neg_ovf;

  assign accept   = (state_q == StAccum) && bus.prod_valid;
  assign prod_ext = {{(ACC_W-PROD_W){bus.prod[PROD_W-1]}}, bus.prod};

  // The sum fits PROD_W bits only if every bit above the result sign bit matches the sign.
  assign top_bits = acc_q[ACC_W-1:PROD_W-1];
  assign pos_ovf  = !acc_q[ACC_W-1] && (|top_bits);
  assign neg_ovf  = acc_q[ACC_W-1] && !(&top_bits);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = (bus.len == '0) ? StSat : StAccum;
      StAccum: if (accept && (count_q == LEN_W'(1))) state_d = StSat;
      StSat:   state_d = StHold;
      StHold:  if (bus.res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.prod_ready = (state_q == StAccum);
    bus.res_valid  = (state_q == StHold);
    bus.busy       = (state_q != StIdle);
    bus.res        = res_q;
    bus.res_sat    = res_sat_q;
  end

  always_comb begin
    acc_d     = acc_q;
    count_d   = count_q;
    res_d     = res_q;
    res_sat_d = res_sat_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d   = '0;
          count_d = bus.len;
        end
      end
      StAccum: begin
        if (accept) begin
          acc_d   = acc_q + prod_ext;
          count_d = count_q - LEN_W'(1);
        end
      end
      StSat: begin
        if (pos_ovf) begin
          res_d     = {1'b0, {(PROD_W-1){1'b1}}};
          res_sat_d = 1'b1;
        end else if (neg_ovf) begin
          res_d     = {1'b1, {(PROD_W-1){1'b0}}};
          res_sat_d = 1'b1;
        end else begin
          res_d     = acc_q[PROD_W-1:0];
          res_sat_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      count_q   <= '0;
      res_q     <= '0;
      res_sat_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      count_q   <= count_d;
      res_q     <= res_d;
      res_sat_q <= res_sat_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed scenarios plus randomized bursts
// compared against a wide-integer sum-and-clamp model.
module tb_mac_accumulator;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned ACC_W  = 72;
  localparam int unsigned LEN_W  = 8;
  localparam logic [63:0] MaxP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MinP = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mac_accumulator_if #(.PROD_W(PROD_W), .LEN_W(LEN_W)) bus ();

  mac_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: exact sum in 128-bit signed arithmetic, then clamp. Returns {sat, res}.
  function automatic logic [64:0] model(input logic [63:0] q[$]);
    logic signed [127:0] s;
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    logic signed [63:0]  v;
    s  = '0;
    hi = 128'sh7FFF_FFFF_FFFF_FFFF;
    lo = -128'sh8000_0000_0000_0000;
    foreach (q[i]) begin
      v = q[i];
      s = s + v;
    end
    if (s > hi) return {1'b1, MaxP};
    if (s < lo) return {1'b1, MinP};
    return {1'b0, s[63:0]};
  endfunction

  task automatic start_burst(input int n);
    logic [31:0] nv;
    nv        = n;
    bus.len   = nv[LEN_W-1:0];
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Present one product after 'gap' idle cycles; returns just after the accepting edge.
  task automatic feed(input logic [63:0] p, input int gap);
    int k;
    repeat (gap) begin @(posedge clk); #1; end
    bus.prod       = p;
    bus.prod_valid = 1'b1;
    k = 0;
    while (!bus.prod_ready && k < 100) begin @(posedge clk); #1; k++; end
    if (!bus.prod_ready) begin
      checks++; errors++;
      $display("FAIL feed_timeout: prod_ready=0 required 1");
    end else begin
      @(posedge clk); #1;
    end
    bus.prod_valid = 1'b0;
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (!bus.res_valid && cyc < 300) begin @(posedge clk); #1; cyc++; end
    if (!bus.res_valid) begin
      checks++; errors++;
      $display("FAIL res_timeout: res_valid=0 required 1");
    end
  endtask

  task automatic take_res();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic run_burst(input logic [63:0] q[$], input int gapmax,
                           output logic [63:0] r, output logic s);
    int cyc;
    start_burst(q.size());
    foreach (q[i]) feed(q[i], $urandom_range(0, gapmax));
    wait_res(cyc);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    r = bus.res;
    s = bus.res_sat;
    take_res();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.res, bus.res_sat, bus.res_valid, bus.prod_ready, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got res=%h sat=%b rv=%b pr=%b busy=%b required all 0",
               bus.res, bus.res_sat, bus.res_valid, bus.prod_ready, bus.busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: got %b required 0", bus.busy);
    end
  endtask

  task automatic test_basic_sum();
    int cyc;
    start_burst(3);
    checks++;
    if (bus.prod_ready !== 1'b1) begin
      errors++; $display("FAIL basic_ready_after_start: got %b required 1", bus.prod_ready);
    end
    feed(64'd5, 0);
    feed(-64'sd7, 0);
    feed(64'd10, 0);
    checks++;
    if (bus.prod_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_sat_cycle: got pr=%b rv=%b required 0 0",
               bus.prod_ready, bus.res_valid);
    end
    wait_res(cyc);
    checks++;
    if (cyc !== 1) begin
      errors++; $display("FAIL basic_latency: got %0d required 1", cyc);
    end
    checks++;
    if (bus.res !== 64'd8 || bus.res_sat !== 1'b0) begin
      errors++; $display("FAIL basic_sum: got %h/%b required 8/0", bus.res, bus.res_sat);
    end
    take_res();
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: got rv=%b busy=%b required 0 0", bus.res_valid, bus.busy);
    end
  endtask

  task automatic test_saturation();
    logic [63:0] q[$];
    logic [63:0] r;
    logic        s;
    q = '{MaxP, MaxP};
    run_burst(q, 0, r, s);
    checks++;
    if (r !== MaxP || s !== 1'b1) begin
      errors++; $display("FAIL pos_sat: got %h/%b required %h/1", r, s, MaxP);
    end
    q = '{MinP, MinP};
    run_burst(q, 0, r, s);
    checks++;
    if (r !== MinP || s !== 1'b1) begin
      errors++; $display("FAIL neg_sat: got %h/%b required %h/1", r, s, MinP);
    end
  endtask

  task automatic test_zero_len_and_gaps();
    int          cyc;
    int          idx;
    logic [63:0] prods[4];
    bit          pat[7];
    start_burst(0);
    wait_res(cyc);
    checks++;
    if (cyc !== 1 || bus.res !== 64'd0 || bus.res_sat !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: got lat=%0d res=%h sat=%b required 1/0/0",
               cyc, bus.res, bus.res_sat);
    end
    take_res();
    prods = '{64'd1, 64'd2, 64'd3, 64'd4};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    start_burst(4);
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      bus.prod_valid = pat[i];
      bus.prod       = prods[idx];
      @(posedge clk); #1;
      if (pat[i]) idx++;
    end
    bus.prod_valid = 1'b0;
    wait_res(cyc);
    checks++;
    if (bus.res !== 64'd10 || bus.res_sat !== 1'b0) begin
      errors++; $display("FAIL gaps_sum: got %h/%b required 10/0", bus.res, bus.res_sat);
    end
    take_res();
  endtask

  task automatic test_backpressure();
    int cyc;
    start_burst(1);
    feed(64'd42, 0);
    wait_res(cyc);
    bus.len = 8'd3;
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++;
      if (bus.res !== 64'd42 || bus.res_valid !== 1'b1 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: got res=%h rv=%b busy=%b required 2a/1/1",
                 i, bus.res, bus.res_valid, bus.busy);
      end
    end
    take_res();
    checks++;
    if (bus.busy !== 1'b0 || bus.res !== 64'd42) begin
      errors++;
      $display("FAIL bp_release: got busy=%b res=%h required 0/2a", bus.busy, bus.res);
    end
    start_burst(0);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL bp_restart: got busy=%b required 1", bus.busy);
    end
    wait_res(cyc);
    take_res();
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] q[$];
    logic [63:0] r;
    logic        s;
    start_burst(3);
    feed(64'd100, 0);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.res, bus.res_sat, bus.res_valid, bus.prod_ready, bus.busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got res=%h sat=%b rv=%b pr=%b busy=%b required all 0",
               bus.res, bus.res_sat, bus.res_valid, bus.prod_ready, bus.busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q = '{64'hFFFF_FFFF_FFFF_FFFD};
    run_burst(q, 1, r, s);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFD || s !== 1'b0) begin
      errors++; $display("FAIL post_reset_burst: got %h/%b required fffffffffffffffd/0", r, s);
    end
  endtask

  // 255 products whose running total leaves 64-bit range but ends back inside it.
  task automatic test_long_burst();
    logic [63:0] q[$];
    logic [63:0] r;
    logic        s;
    logic [64:0] exp;
    for (int i = 0; i < 128; i++) q.push_back(MaxP);
    for (int i = 0; i < 127; i++) q.push_back(MinP);
    exp = model(q);
    run_burst(q, 0, r, s);
    checks++;
    if ({s, r} !== exp) begin
      errors++; $display("FAIL long_burst: got %b/%h required %b/%h", s, r, exp[64], exp[63:0]);
    end
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic [63:0] r;
    logic        s;
    logic [64:0] exp;
    int          n;
    int          v;
    for (int it = 0; it < 30; it++) begin
      q.delete();
      n = $urandom_range(0, 6);
      for (int j = 0; j < n; j++) begin
        v = $urandom_range(0, 2000);
        case ($urandom_range(0, 3))
          0: q.push_back(MaxP - 64'($urandom_range(0, 3)));
          1: q.push_back(MinP + 64'($urandom_range(0, 3)));
          2: q.push_back({$urandom, $urandom});
          default: q.push_back(64'(longint'(v) - 64'sd1000));
        endcase
      end
      exp = model(q);
      run_burst(q, 2, r, s);
      checks++;
      if ({s, r} !== exp) begin
        errors++;
        $display("FAIL random%0d: got %b/%h required %b/%h", it, s, r, exp[64], exp[63:0]);
      end
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.len        = '0;
    bus.prod       = '0;
    bus.prod_valid = 1'b0;
    bus.res_ready  = 1'b0;
    test_reset();
    test_basic_sum();
    test_saturation();
    test_zero_len_and_gaps();
    test_backpressure();
    test_reset_mid_burst();
    test_long_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Downstream consumer of the 32x32 signed sequential multiplier's 64-bit products. It accepts a burst of `len` signed products over a valid/ready handshake and sums them in a wide internal accumulator. At the end of the burst it presents one saturated 64-bit result, with a saturation flag, over a second valid/ready handshake. This gives the datapath a dot-product / MAC stage without widening the multiplier.

## Interface

Parameters:
- `PROD_W`, default 64: product width (signed, two's complement).
- `ACC_W`, default 72: internal accumulator width.
- `LEN_W`, default 8: burst-length width.
- Constraint: `LEN_W <= ACC_W - PROD_W`, so the accumulator can never overflow internally.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: burst start pulse; sampled only in IDLE.
- `len`, in, LEN_W: number of products in the burst, unsigned; sampled with `start`.
- `prod`, in, PROD_W: signed product from the multiplier.
- `prod_valid`, in, 1: `prod` is valid.
- `prod_ready`, out, 1: block accepts `prod` this cycle.
- `res`, out, PROD_W: signed saturated sum.
- `res_sat`, out, 1: `res` was clamped.
- `res_valid`, out, 1: `res` / `res_sat` are valid.
- `res_ready`, in, 1: consumer takes the result.
- `busy`, out, 1: high in any state other than IDLE.

## Operation

- **Reset values.** While `rst` is high, and immediately on its assertion, the block forces:
  - state = IDLE; accumulator = 0; count = 0;
  - `res` = 0, `res_sat` = 0;
  - `res_valid` = 0, `prod_ready` = 0, `busy` = 0.
- **State machine:** IDLE, ACCUM, SAT, HOLD.
- **IDLE**
  - `start`=1 with `len`>0: accumulator := 0, count := `len`, go to ACCUM.
  - `start`=1 with `len`=0: accumulator := 0, go to SAT, producing a result of 0.
  - `start`=0: stay in IDLE.
- **ACCUM**
  - `prod_ready`=1.
  - A product is accepted on every edge where `prod_valid & prod_ready`. On acceptance: accumulator += sign-extend(`prod`) to ACC_W, and count -= 1.
  - When the accepted product is the last one (count was 1), go to SAT.
  - Gaps in `prod_valid` are allowed and just stall the burst; there is no timeout.
- **SAT** (one cycle, `prod_ready`=0)
  - If accumulator > 2^(PROD_W-1)-1: `res` := 0x7FFF_FFFF_FFFF_FFFF, `res_sat` := 1.
  - Else if accumulator < -2^(PROD_W-1): `res` := 0x8000_0000_0000_0000, `res_sat` := 1.
  - Otherwise: `res` := accumulator[PROD_W-1:0], `res_sat` := 0.
  - Go to HOLD.
- **HOLD**
  - `res_valid`=1; `res` and `res_sat` stay stable.
  - On an edge with `res_ready`=1: go to IDLE, and `res_valid` drops.
  - `start` is ignored in HOLD.
- **Outside IDLE**, `start` and `len` are ignored.
- **Holding of outputs.** `res` and `res_sat` keep their last values after leaving HOLD, until the next SAT state.
- **Reset mid-burst** (any state): the burst is abandoned and no result is produced. After `rst` drops, the next `start` begins a fresh burst.

## Timing

- `start` is sampled at edge S.
  - With `len`>0, `prod_ready`=1 from the cycle after S.
  - With `len`=0, `res_valid`=1 two cycles after S (IDLE→SAT→HOLD).
- The last product is accepted at edge N:
  - `prod_ready`=0 in the cycle after N (SAT);
  - `res_valid`=1 from the cycle after edge N+1.
- Minimum burst duration is `len` + 2 cycles from the first accept-ready cycle to result.
- The earliest next `start` is sampled one cycle after the `res_valid & res_ready` edge.
- `prod_ready` and `res_valid` are registered state decodes, with no combinational path from inputs.
- The result stays valid indefinitely under backpressure.

## Test plan

- **Basic sum:** `len`=3, prods 5, -7, 10 back-to-back → one `res_valid` pulse with `res`=8, `res_sat`=0, arriving 2 cycles after the last accept.
- **Positive saturation:** `len`=2, prods 0x7FFF_FFFF_FFFF_FFFF twice → `res`=0x7FFF_FFFF_FFFF_FFFF, `res_sat`=1.
- **Negative saturation:** `len`=2, prods 0x8000_0000_0000_0000 twice → `res`=0x8000_0000_0000_0000, `res_sat`=1.
- **Zero-length and gaps:**
  - `len`=0 → `res`=0, `res_sat`=0, `res_valid` 2 cycles after `start`.
  - `len`=4 with `prod_valid` toggling 1,0,0,1,1,0,1 on prods 1, 2, 3, 4 → `res`=10.
- **Backpressure:** `res_ready` held low for 5 cycles in HOLD while `start` pulses → `res` stable, `busy`=1, `start` ignored. Then `res_ready`=1 → IDLE, and a new `start` is accepted the following cycle.
- **Reset mid-burst:** assert `rst` after 1 of 3 products → all outputs are 0 in the same cycle. Then `len`=1, prod -3 → `res`=0xFFFF_FFFF_FFFF_FFFD, `res_sat`=0.
